// File: rtl/regfile_wr_port_pkg.sv
// Shared constants and request type for the register-file write port.
// Only the default AW/DW geometry is supported by wr_req_t.
package regfile_wr_port_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;
    localparam int NREGS  = 1 << REG_AW;

    localparam logic [REG_AW-1:0] ZERO_ADDR = '0;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wr_req_t;

    // r0 is hardwired zero, so a write to it enables no row at all.
    function automatic logic [NREGS-1:0] onehot_row(input logic [REG_AW-1:0] a);
        onehot_row = '0;
        if (a != ZERO_ADDR) begin
            onehot_row[a] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/regfile_wr_fifo.sv
// Generic DEPTH-entry synchronous FIFO; push is ignored when full, pop when empty.
// Entries are exposed oldest-first (index 0 = head) with per-slot valid bits.
module regfile_wr_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic [W-1:0]                 push_dat,
    input  logic                         pop,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         empty,
    output logic [DEPTH-1:0][W-1:0]      ord_dat,
    output logic [DEPTH-1:0]             ord_vld
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [PW-1:0]           idx;
    logic                    do_push, do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        idx     = '0;
        ord_dat = '0;
        ord_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx        = rd_ptr_q + PW'(i);
            ord_dat[i] = mem_q[idx];
            ord_vld[i] = (CW'(i) < cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/regfile_wr_port.sv
// Register-file write port: queues requests, retires one per cycle as one-hot we + wdata.
// Accepted at edge N, driven on we/wdata in cycle N+1; wr_ready drops only when the queue is full.
module regfile_wr_port
    import regfile_wr_port_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = REG_AW,
    parameter int DW    = REG_DW
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [AW-1:0]           wr_addr,
    input  logic [DW-1:0]           wr_data,
    input  logic                    hold,
    output logic [(1<<AW)-1:0]      we,
    output logic [DW-1:0]           wdata,
    input  logic [AW-1:0]           rd_addr,
    output logic                    byp_hit,
    output logic [DW-1:0]           byp_data,
    output logic [$clog2(DEPTH):0]  pending
);

    localparam int EW = $bits(wr_req_t);

    wr_req_t                 push_req;
    wr_req_t                 head;
    wr_req_t                 ent;
    logic [DEPTH-1:0][EW-1:0] ord_dat;
    logic [DEPTH-1:0]        ord_vld;
    logic                    full, empty;
    logic                    push, retire;

    assign push_req = '{addr: wr_addr, data: wr_data};
    assign wr_ready = ~full;
    assign push     = wr_valid & wr_ready;
    assign retire   = ~empty & ~hold;
    assign head     = ord_dat[0];

    regfile_wr_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push),
        .push_dat (push_req),
        .pop      (retire),
        .count    (pending),
        .full     (full),
        .empty    (empty),
        .ord_dat  (ord_dat),
        .ord_vld  (ord_vld)
    );

    always_comb begin
        we    = '0;
        wdata = '0;
        if (retire) begin
            we    = onehot_row(head.addr);
            wdata = head.data;
        end
    end

    // Oldest-to-youngest scan: later matches overwrite, leaving the youngest.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        ent      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent = ord_dat[i];
            if (ord_vld[i] && (ent.addr == rd_addr) && (rd_addr != ZERO_ADDR)) begin
                byp_hit  = 1'b1;
                byp_data = ent.data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wr_port.sv
// Bench for regfile_wr_port: hand-computed vector table plus a retirement scoreboard,
// followed by a randomised phase checked against a small queue model.
module tb_regfile_wr_port;

    localparam int DEPTH = 2;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          hold;
    logic [31:0]   we;
    logic [DW-1:0] wdata;
    logic [AW-1:0] rd_addr;
    logic          byp_hit;
    logic [DW-1:0] byp_data;
    logic [1:0]    pending;

    always #5 clk = ~clk;

    regfile_wr_port #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .hold     (hold),
        .we       (we),
        .wdata    (wdata),
        .rd_addr  (rd_addr),
        .byp_hit  (byp_hit),
        .byp_data (byp_data),
        .pending  (pending)
    );

    typedef struct {
        logic        rst_n;
        logic        v;
        logic [4:0]  a;
        logic [31:0] d;
        logic        h;
        logic [4:0]  ra;
        logic        rdy;
        int          pend;
        logic        hit;
        logic [31:0] bd;
    } vec_t;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } req_t;

    vec_t tbl[$];
    req_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic add(input logic rst_n, input logic v, input logic [4:0] a, input logic [31:0] d,
                       input logic h, input logic [4:0] ra, input logic rdy, input int pend,
                       input logic hit, input logic [31:0] bd);
        vec_t x;
        x.rst_n = rst_n; x.v = v; x.a = a; x.d = d; x.h = h; x.ra = ra;
        x.rdy = rdy; x.pend = pend; x.hit = hit; x.bd = bd;
        tbl.push_back(x);
    endtask

    // One cycle: drive at negedge, check settled outputs, then model the coming edge.
    task automatic step(input vec_t e, input bit use_tbl);
        req_t        r;
        logic [31:0] exp_we, exp_wd, m_bd;
        logic        m_hit, m_rdy, ret;
        @(negedge clk);
        reset_n = e.rst_n; wr_valid = e.v; wr_addr = e.a; wr_data = e.d;
        hold = e.h; rd_addr = e.ra;
        #1;
        m_rdy = (sb.size() < DEPTH);
        m_hit = 1'b0; m_bd = '0;
        foreach (sb[i]) if (sb[i].a == e.ra && e.ra != 0) begin m_hit = 1'b1; m_bd = sb[i].d; end
        if (use_tbl) begin
            chk("wr_ready", wr_ready, e.rdy);
            chk("pending",  pending, e.pend);
            chk("byp_hit",  byp_hit, e.hit);
            chk("byp_data", byp_data, e.bd);
        end else begin
            chk("rnd_wr_ready", wr_ready, m_rdy);
            chk("rnd_pending",  pending, sb.size());
            chk("rnd_byp_hit",  byp_hit, m_hit);
            chk("rnd_byp_data", byp_data, m_bd);
            chk("we_onehot0",   {63'd0, $onehot0(we) && !we[0]}, 64'd1);
        end
        ret = (sb.size() > 0) && !e.h;
        exp_we = '0; exp_wd = '0;
        if (ret) begin
            r = sb.pop_front();
            exp_we = (r.a == 0) ? 32'd0 : (32'd1 << r.a);
            exp_wd = r.d;
        end
        chk("we", we, exp_we);
        chk("wdata", wdata, exp_wd);
        if (!e.rst_n) sb.delete();
        else if (e.v && m_rdy) sb.push_back('{a: e.a, d: e.d});
    endtask

    initial begin
        vec_t x;
        reset_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; hold = 1'b0; rd_addr = '0;
        repeat (2) @(posedge clk);

        //   rst v  a   d             h  ra  rdy pend hit bd
        add(1, 0, 0,  32'h0,        0, 0,  1,  0,   0,  32'h0);          // reset state
        add(1, 1, 5,  32'hDEADBEEF, 0, 5,  1,  0,   0,  32'h0);          // single write
        add(1, 0, 0,  32'h0,        0, 5,  1,  1,   1,  32'hDEADBEEF);
        add(1, 0, 0,  32'h0,        0, 0,  1,  0,   0,  32'h0);
        add(1, 1, 3,  32'h33,       1, 3,  1,  0,   0,  32'h0);          // fill under hold
        add(1, 1, 4,  32'h44,       1, 3,  1,  1,   1,  32'h33);
        add(1, 1, 6,  32'h66,       1, 4,  0,  2,   1,  32'h44);
        add(1, 1, 6,  32'h66,       0, 3,  0,  2,   1,  32'h33);
        add(1, 1, 6,  32'h66,       0, 6,  1,  1,   0,  32'h0);
        add(1, 0, 0,  32'h0,        0, 6,  1,  1,   1,  32'h66);
        add(1, 0, 0,  32'h0,        0, 0,  1,  0,   0,  32'h0);
        add(1, 1, 7,  32'h11,       1, 7,  1,  0,   0,  32'h0);          // bypass youngest
        add(1, 1, 7,  32'h22,       1, 7,  1,  1,   1,  32'h11);
        add(1, 0, 0,  32'h0,        1, 7,  0,  2,   1,  32'h22);
        add(1, 0, 0,  32'h0,        1, 0,  0,  2,   0,  32'h0);
        add(1, 0, 0,  32'h0,        1, 9,  0,  2,   0,  32'h0);
        add(1, 0, 0,  32'h0,        0, 7,  0,  2,   1,  32'h22);
        add(1, 0, 0,  32'h0,        0, 7,  1,  1,   1,  32'h22);
        add(1, 0, 0,  32'h0,        0, 7,  1,  0,   0,  32'h0);
        add(1, 1, 0,  32'hFFFFFFFF, 0, 0,  1,  0,   0,  32'h0);          // r0 write
        add(1, 0, 0,  32'h0,        0, 0,  1,  1,   0,  32'h0);
        add(1, 0, 0,  32'h0,        0, 0,  1,  0,   0,  32'h0);
        for (int k = 1; k <= 8; k++)                                     // streaming
            add(1, 1, 5'(k), 32'h100 + k, 0, 5'(k - 1), 1, (k == 1) ? 0 : 1,
                (k == 1) ? 1'b0 : 1'b1, (k == 1) ? 32'h0 : 32'h100 + k - 1);
        add(1, 0, 0,  32'h0,        0, 8,  1,  1,   1,  32'h108);
        add(1, 0, 0,  32'h0,        0, 0,  1,  0,   0,  32'h0);
        add(1, 1, 10, 32'hA,        1, 10, 1,  0,   0,  32'h0);          // reset mid-operation
        add(1, 1, 11, 32'hB,        1, 10, 1,  1,   1,  32'hA);
        add(0, 0, 0,  32'h0,        1, 10, 0,  2,   1,  32'hA);
        add(1, 0, 0,  32'h0,        1, 10, 1,  0,   0,  32'h0);
        add(1, 0, 0,  32'h0,        0, 11, 1,  0,   0,  32'h0);
        add(1, 0, 0,  32'h0,        0, 10, 1,  0,   0,  32'h0);

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b1);

        // Randomised traffic with hold bursts, same-address collisions and a rare reset.
        for (int i = 0; i < 400; i++) begin
            x.rst_n = ($urandom_range(0, 63) != 0);
            x.v     = $urandom_range(0, 1);
            x.a     = 5'($urandom_range(0, 7));
            x.d     = $urandom;
            x.h     = ($urandom_range(0, 3) == 0);
            x.ra    = 5'($urandom_range(0, 7));
            x.rdy = 1'b0; x.pend = 0; x.hit = 1'b0; x.bd = '0;
            step(x, 1'b0);
        end
        x.rst_n = 1'b1; x.v = 1'b0; x.h = 1'b0;
        for (int i = 0; i < 4; i++) step(x, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_wr_port.md
Name: regfile_wr_port

Overview:
- Write-side counterpart of the register-file read path.
- Accepts register write requests over a valid/ready handshake and queues them in a small FIFO.
- Retires one write per cycle as a one-hot row write-enable plus data into the 32x32 register array.
- Provides a read-bypass lookup so read-port logic sees queued, not-yet-retired data.

Parameters:
- DEPTH, 2, pending-write FIFO entries (power of two, 2..8)
- AW, 5, register address width (2^AW registers)
- DW, 32, register data width

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset
- wr_valid  input  1  write request valid
- wr_ready  output  1  request accepted when wr_valid & wr_ready at clk edge
- wr_addr  input  AW  destination register
- wr_data  input  DW  write data
- hold  input  1  register array busy; suppresses retirement this cycle
- we  output  2^AW  one-hot row write enable to register array
- wdata  output  DW  data for the enabled row
- rd_addr  input  AW  read-port address for bypass lookup
- byp_hit  output  1  rd_addr matches a pending write
- byp_data  output  DW  data of youngest matching pending write
- pending  output  $clog2(DEPTH)+1  number of queued writes

Behaviour:
- Reset and width rules:
  - Synchronous, active-low reset: reset_n sampled low at a clk edge empties the FIFO (pointers and count to 0).
  - After that edge: we=0, wdata=0, byp_hit=0, byp_data=0, pending=0, wr_ready=1.
  - Reset mid-operation discards all queued writes; none retire.
  - All arithmetic is unsigned. Pointers wrap modulo DEPTH.
- Accept:
  - wr_ready = (pending < DEPTH). It is independent of wr_valid and of this cycle's retirement; full means not ready even if a pop occurs.
  - On handshake, {wr_addr, wr_data} are written at the tail.
  - Writes to address 0 are accepted and occupy an entry, but retire with we=0 (r0 hardwired zero).
- Retire (combinational from FIFO head):
  - When pending>0 and hold=0: we = one-hot(head.addr), or all zeros if head.addr=0; wdata = head.data. The head pops at the clk edge.
  - Otherwise we=0 and wdata=0.
  - Latency: a request accepted at edge N drives we/wdata during cycle N+1 (if empty and not held), and the array latches it at edge N+1.
  - hold asserted: head is retained, we=0, accepts still allowed while not full.
- Simultaneous push and pop: pending is unchanged, and order is preserved (strict FIFO). Two writes to the same address retire in order, so the last write wins.
- Bypass (combinational):
  - Search all valid entries, including the head being retired this cycle.
  - byp_hit=1 if any entry's addr equals rd_addr and rd_addr≠0.
  - byp_data = data of the youngest such entry, else 0.
  - The request currently on wr_* is not searched; it becomes visible the cycle after acceptance.
- Invariants:
  - we is always zero or one-hot; we[0] is never 1.
  - pending ≤ DEPTH.

Decomposition:
- Shared package:
  - AW/DW/NREGS constants
  - wr_req typedef {addr, data}
  - the zero-register address constant
- One sub-module: regfile_wr_fifo, a generic DEPTH-entry sync FIFO that exposes all entries plus valid bits for the bypass search.
- Top-level logic: one-hot decode, hold gating, youngest-match priority search.

Test Plan:
- Single write, empty, hold=0: accept addr=5 data=0xDEADBEEF at edge 0 -> cycle 1 we=0x00000020, wdata=0xDEADBEEF; cycle 2 we=0, pending=0.
- Fill under hold: hold=1, push addr 3 then addr 4 -> pending=2, wr_ready=0, third request stalls. Release hold -> we=0x8 then 0x10 on consecutive cycles; wr_ready returns 1 the cycle after the first pop.
- Bypass youngest: hold=1, push (7,0x11) then (7,0x22), rd_addr=7 -> byp_hit=1, byp_data=0x22. rd_addr=0 or 9 -> byp_hit=0, byp_data=0.
- r0 write: push addr 0 data 0xFFFFFFFF -> pending goes to 1, then retires with we=0; rd_addr=0 never hits.
- Streaming: wr_valid held high with addrs 1..8 and hold=0 -> one accept and one retire per cycle, pending stays at 1, we sequence 0x2,0x4,...,0x100 in order.
- Reset mid-operation: two entries queued under hold, reset_n low one cycle -> next cycle pending=0, we=0, byp_hit=0, wr_ready=1, no retirement after hold drops.
